// File: rtl/fb_arbiter.sv
// fb_arbiter: double-buffered frame buffer arbiter sharing one single-port RAM.
// Define FB_AUTO_CLEAR_EN to zero-fill the new back bank after every swap.
module fb_arbiter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)+1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [9:0]        disp_x,
  input  logic [8:0]        disp_y,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  input  logic              frame_end,
  output logic              swap_pending,
  output logic              front_sel,
  output logic [15:0]       frame_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int NPIX  = WIDTH * HEIGHT;

`ifdef FB_AUTO_CLEAR_EN
  typedef enum logic [1:0] {DRAW, WAIT_SWAP, CLEAR} state_t;
  logic [IDX_W-1:0] clr_cnt;
`else
  typedef enum logic [1:0] {DRAW, WAIT_SWAP} state_t;
`endif

  state_t           state;
  logic             rd_v1, rd_ok1, rd_ok2;
  logic             disp_in, wr_in;
  logic [IDX_W-1:0] disp_idx, wr_idx;

  assign disp_in  = (32'(disp_x) < WIDTH) && (32'(disp_y) < HEIGHT);
  assign wr_in    = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
  assign disp_idx = IDX_W'(disp_y) * IDX_W'(WIDTH) + IDX_W'(disp_x);
  assign wr_idx   = IDX_W'(wr_y) * IDX_W'(WIDTH) + IDX_W'(wr_x);
  assign wr_ready = (state == DRAW) && !disp_req;

  // RAM data arrives two cycles after the request; out-of-range reads return zero.
  assign disp_data = rd_ok2 ? mem_rdata : '0;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= DRAW;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      frame_count  <= '0;
      rd_v1        <= 1'b0;
      rd_ok1       <= 1'b0;
      disp_valid   <= 1'b0;
      rd_ok2       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
`ifdef FB_AUTO_CLEAR_EN
      clr_cnt      <= '0;
`endif
    end else begin
      rd_v1      <= disp_req;
      rd_ok1     <= disp_req && disp_in;
      disp_valid <= rd_v1;
      rd_ok2     <= rd_ok1;
      mem_we     <= 1'b0;

      // One RAM access per cycle: display read, then renderer write, then clear.
      if (disp_req) begin
        if (disp_in)
          mem_addr <= {front_sel, disp_idx};
      end else if (wr_ready && wr_valid) begin
        if (wr_in) begin
          mem_we    <= 1'b1;
          mem_addr  <= {~front_sel, wr_idx};
          mem_wdata <= wr_data;
        end
      end
`ifdef FB_AUTO_CLEAR_EN
      else if (state == CLEAR) begin
        mem_we    <= 1'b1;
        mem_addr  <= {~front_sel, clr_cnt};
        mem_wdata <= '0;
      end
`endif

      case (state)
        DRAW: begin
          if (swap_req) begin
            state        <= WAIT_SWAP;
            swap_pending <= 1'b1;
          end
        end
        WAIT_SWAP: begin
          if (frame_end) begin
            front_sel    <= ~front_sel;
            frame_count  <= frame_count + 16'd1;
            swap_pending <= 1'b0;
`ifdef FB_AUTO_CLEAR_EN
            state        <= CLEAR;
            clr_cnt      <= '0;
`else
            state        <= DRAW;
`endif
          end
        end
`ifdef FB_AUTO_CLEAR_EN
        CLEAR: begin
          if (!disp_req) begin
            if (clr_cnt == IDX_W'(NPIX - 1))
              state <= DRAW;
            clr_cnt <= clr_cnt + IDX_W'(1);
          end
        end
`endif
        default: state <= DRAW;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: a behavioural model queues expected RAM ops and read data.
module tb_fb_arbiter;

  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int DATA_W = 8;
  localparam int ADDR_W = $clog2(WIDTH*HEIGHT)+1;
  localparam int IDX_W  = ADDR_W - 1;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic              disp_req = 1'b0;
  logic [9:0]        disp_x = '0;
  logic [8:0]        disp_y = '0;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [9:0]        wr_x = '0;
  logic [8:0]        wr_y = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              swap_req = 1'b0;
  logic              frame_end = 1'b0;
  logic              swap_pending;
  logic              front_sel;
  logic [15:0]       frame_count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  fb_arbiter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .swap_req(swap_req), .frame_end(frame_end), .swap_pending(swap_pending),
    .front_sel(front_sel), .frame_count(frame_count),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Synchronous single-port RAM: data valid the cycle after the address is sampled.
  logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  always @(posedge CLOCK_50) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct { int cyc; logic [DATA_W-1:0] data; } rd_exp_t;
  typedef struct { int cyc; logic we; logic chk; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wd; } mem_exp_t;
  typedef enum {M_DRAW, M_WAIT, M_CLEAR} mstate_t;

  rd_exp_t  rd_q[$];
  mem_exp_t mem_q[$];

  mstate_t     m_state = M_DRAW;
  logic        m_front = 1'b0;
  logic        m_pending = 1'b0;
  logic [15:0] m_count = '0;
  int          m_clr = 0;

  int n_checks = 0;
  int n_pass = 0;
  int clear_zero_writes = 0;

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'(a >>> 8) ^ 8'h5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
  endtask

  // Monitor: retire expected RAM ops one cycle after issue and read data two cycles after.
  always @(negedge CLOCK_50) begin
    mem_exp_t me;
    rd_exp_t  re;
    if (!reset) begin
      while (mem_q.size() > 0 && mem_q[0].cyc + 1 <= cyc) begin
        me = mem_q.pop_front();
        checkOutput("mem_we", 32'(mem_we), 32'(me.we));
        if (me.chk) begin
          checkOutput("mem_addr", 32'(mem_addr), 32'(me.addr));
          if (me.we) checkOutput("mem_wdata", 32'(mem_wdata), 32'(me.wd));
        end
      end
      if (disp_valid) begin
        if (rd_q.size() == 0) checkOutput("disp_valid", 32'(disp_valid), 32'(0));
        else begin
          re = rd_q.pop_front();
          checkOutput("disp_latency", 32'(cyc), 32'(re.cyc + 2));
          checkOutput("disp_data", 32'(disp_data), 32'(re.data));
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc + 2 <= cyc) begin
        re = rd_q.pop_front();
        checkOutput("disp_valid", 32'(disp_valid), 32'(1));
      end
      if (mem_we && !mem_addr[ADDR_W-1] && mem_wdata == '0) clear_zero_writes++;
    end
  end

  task automatic applyStimulus(input logic dr, input logic [9:0] dx, input logic [8:0] dy,
                               input logic wv, input logic [9:0] wx, input logic [8:0] wy,
                               input logic [7:0] wd, input logic sr, input logic fe);
    mem_exp_t me;
    rd_exp_t  re;
    mstate_t  old;
    logic     inr;
    @(posedge CLOCK_50); #1;
    checkOutput("front_sel", 32'(front_sel), 32'(m_front));
    checkOutput("swap_pending", 32'(swap_pending), 32'(m_pending));
    checkOutput("frame_count", 32'(frame_count), 32'(m_count));
    disp_req = dr; disp_x = dx; disp_y = dy;
    wr_valid = wv; wr_x = wx; wr_y = wy; wr_data = wd;
    swap_req = sr; frame_end = fe;
    #1;
    checkOutput("wr_ready", 32'(wr_ready), 32'((m_state == M_DRAW) && !dr));
    old = m_state;
    me.cyc = cyc; me.we = 1'b0; me.chk = 1'b0; me.addr = '0; me.wd = '0;
    if (dr) begin
      inr = (int'(dx) < WIDTH) && (int'(dy) < HEIGHT);
      me.chk  = inr;
      me.addr = {m_front, IDX_W'(int'(dy) * WIDTH + int'(dx))};
      re.cyc  = cyc;
      re.data = inr ? shadow[me.addr] : '0;
      rd_q.push_back(re);
    end else if (wv && old == M_DRAW) begin
      if ((int'(wx) < WIDTH) && (int'(wy) < HEIGHT)) begin
        me.we = 1'b1; me.chk = 1'b1; me.wd = wd;
        me.addr = {~m_front, IDX_W'(int'(wy) * WIDTH + int'(wx))};
        shadow[me.addr] = wd;
      end
    end else if (old == M_CLEAR) begin
      me.we = 1'b1; me.chk = 1'b1; me.wd = '0;
      me.addr = {~m_front, IDX_W'(m_clr)};
      shadow[me.addr] = '0;
    end
    mem_q.push_back(me);
    case (old)
      M_DRAW: if (sr) begin m_state = M_WAIT; m_pending = 1'b1; end
      M_WAIT: if (fe) begin
        m_front = ~m_front; m_count++; m_pending = 1'b0;
`ifdef FB_AUTO_CLEAR_EN
        m_state = M_CLEAR; m_clr = 0;
`else
        m_state = M_DRAW;
`endif
      end
      M_CLEAR: if (!dr) begin
        if (m_clr == NPIX - 1) m_state = M_DRAW;
        m_clr++;
      end
      default: ;
    endcase
  endtask

  task automatic idle();
    applyStimulus(1'b0, 10'd0, 9'd0, 1'b0, 10'd0, 9'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(posedge CLOCK_50); #1;
    reset = 1'b1; disp_req = 1'b0; wr_valid = 1'b0; swap_req = 1'b0; frame_end = 1'b0;
    rd_q.delete(); mem_q.delete();
    @(posedge CLOCK_50); #1;
    checkOutput("rst_disp_valid", 32'(disp_valid), 32'(0));
    checkOutput("rst_disp_data", 32'(disp_data), 32'(0));
    checkOutput("rst_mem_we", 32'(mem_we), 32'(0));
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'(0));
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    checkOutput("rst_front_sel", 32'(front_sel), 32'(0));
    checkOutput("rst_swap_pending", 32'(swap_pending), 32'(0));
    checkOutput("rst_frame_count", 32'(frame_count), 32'(0));
    reset = 1'b0;
    m_state = M_DRAW; m_front = 1'b0; m_pending = 1'b0; m_count = '0; m_clr = 0;
  endtask

  initial begin
    int wi;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = pat(i);
      shadow[i] = pat(i);
    end
    doReset();
    while (cyc < 9) idle();

    // Display burst along row 2, columns 3..7, from bank 0.
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, 10'(3 + k), 9'd2, 1'b0, 10'd0, 9'd0, 8'd0, 1'b0, 1'b0);

    // Renderer offers writes while display requests alternate.
    wi = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k % 2 == 0, 10'(k), 9'd3, 1'b1, 10'(5 + wi), 9'd1, 8'(8'hA5 + wi), 1'b0, 1'b0);
      if (k % 2 != 0) wi++;
    end

    // Coordinate boundaries for both paths.
    applyStimulus(1'b0, 10'd0, 9'd0, 1'b1, 10'd160, 9'd0, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd0, 9'd120, 1'b0, 10'd0, 9'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 10'd0, 9'd0, 1'b1, 10'd0, 9'd120, 8'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd160, 9'd0, 1'b0, 10'd0, 9'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 10'd0, 9'd0, 1'b1, 10'd159, 9'd119, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd159, 9'd119, 1'b0, 10'd0, 9'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd1023, 9'd511, 1'b0, 10'd0, 9'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 10'd0, 9'd0, 1'b1, 10'd1023, 9'd511, 8'h33, 1'b0, 1'b0);

    // Swap request coincident with frame_end waits for the next frame_end.
    clear_zero_writes = 0;
    applyStimulus(1'b0, 10'd0, 9'd0, 1'b0, 10'd0, 9'd0, 8'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 10'd0, 9'd0, 1'b1, 10'd9, 9'd9, 8'h44, 1'b1, 1'b0);
    idle();
    applyStimulus(1'b1, 10'd5, 9'd1, 1'b0, 10'd0, 9'd0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 10'd5, 9'd1, 1'b0, 10'd0, 9'd0, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd6, 9'd1, 1'b0, 10'd0, 9'd0, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd159, 9'd119, 1'b0, 10'd0, 9'd0, 8'd0, 1'b0, 1'b0);

    // Any auto-clear runs with 50% display duty and blocked renderer writes.
    for (int k = 0; k < 50000 && m_state != M_DRAW; k++)
      applyStimulus(k % 2 == 0, 10'($urandom_range(0, 159)), 9'($urandom_range(0, 119)),
                    1'b1, 10'd2, 9'd2, 8'h55, 1'b0, 1'b0);
    idle(); idle(); idle();
`ifdef FB_AUTO_CLEAR_EN
    checkOutput("clear_writes", 32'(clear_zero_writes), 32'(NPIX));

    // Second swap, then reset partway through its clear.
    applyStimulus(1'b0, 10'd0, 9'd0, 1'b0, 10'd0, 9'd0, 8'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'd0, 9'd0, 1'b0, 10'd0, 9'd0, 8'd0, 1'b0, 1'b1);
    for (int k = 0; k < 1000 && m_clr < 100; k++)
      applyStimulus(k % 2 == 0, 10'd1, 9'd1, 1'b0, 10'd0, 9'd0, 8'd0, 1'b0, 1'b0);
    doReset();
    for (int k = 0; k < 20; k++) idle();
`endif

    // Mixed random traffic without swaps, including out-of-range coordinates.
    for (int k = 0; k < 300; k++)
      applyStimulus(1'($urandom_range(0, 1)), 10'($urandom_range(0, 170)), 9'($urandom_range(0, 125)),
                    1'($urandom_range(0, 1)), 10'($urandom_range(0, 170)), 9'($urandom_range(0, 125)),
                    8'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) idle();
    checkOutput("reads_outstanding", 32'(rd_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
